fourwires_rx: RTL and testbench
===============================

Name: fourwires_rx

Overview:
Receive-side partner of the fourwires fan-out. The fan-out drives three logic signals onto four wires: w=a, x=b, y=b, z=c, so b travels twice as a redundancy pair. This block is the far end. It synchronizes the four wires, checks that the duplicated b lanes agree, filters glitches, and reconstructs registered a/b/c. It also reports lane-mismatch faults through a saturating counter and a sticky flag.

Parameters:
SYNC_STAGES, 2, synchronizer depth per wire (>=2)
STABLE_CYCLES, 4, consecutive equal samples required before a new value is accepted (>=1)
ERR_CNT_W, 8, width of the mismatch event counter

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
w  in  1  wire carrying a
x  in  1  wire carrying b, primary lane
y  in  1  wire carrying b, redundant lane
z  in  1  wire carrying c
err_clr  in  1  synchronous clear of err_cnt and err_sticky
a  out  1  reconstructed a, registered
b  out  1  reconstructed b, registered
c  out  1  reconstructed c, registered
valid  out  1  one-cycle pulse when {c,b,a} updates
mismatch  out  1  registered flag: synchronized x != synchronized y
err_cnt  out  ERR_CNT_W  count of mismatch events, saturating
err_sticky  out  1  set on any mismatch event; held until err_clr

Behaviour:
- Reset (async assert, sync release):
  - all sync flops, a/b/c, valid, mismatch, err_cnt, err_sticky = 0
  - stability counter = 0; FSM = LOCKED
  - reset asserted mid-operation aborts settling immediately; no valid pulse is produced for an aborted candidate.
- Sync: each of w/x/y/z passes through SYNC_STAGES flops. Outputs ws, xs, ys, zs. Sampled word S = {zs, xs, ws}.
- FSM states LOCKED, SETTLING, FAULT. Evaluated each cycle in priority order:
  - xs != ys (any state): go to FAULT. Stability counter = 0; a/b/c hold.
  - FAULT with xs == ys: load candidate = S, counter = 0, go to SETTLING.
  - LOCKED with S != {c,b,a}: load candidate = S, counter = 0, go to SETTLING.
  - LOCKED with S == {c,b,a}: stay.
  - SETTLING with S != candidate: reload candidate = S, counter = 0.
  - SETTLING with S == candidate and counter < STABLE_CYCLES-1: increment counter.
  - SETTLING with S == candidate and counter == STABLE_CYCLES-1:
    - if candidate != {c,b,a}: {c,b,a} <= candidate and valid = 1 next cycle
    - either way, go to LOCKED
    - a glitch that returns to the current output value produces no valid pulse.
- Latency: a clean input change is visible on a/b/c, with valid high, exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge that samples it. Defaults give 6 edges.
- valid is high for exactly one cycle per update. Back-to-back updates are separated by at least STABLE_CYCLES cycles.
- mismatch is registered (xs != ys), one cycle after the sync output.
- A mismatch event is the rising edge of mismatch (0 -> 1). On each event:
  - err_cnt += 1, saturating at all-ones
  - err_sticky = 1
- A continuous mismatch counts once.
- err_clr: err_cnt = 0, err_sticky = 0 next cycle. If err_clr and an event occur in the same cycle, the event wins: err_cnt = 1, err_sticky = 1.
- a/b/c hold their last accepted value throughout FAULT.

Decomposition:
- Package fourwires_pkg:
  - FSM state enum (LOCKED, SETTLING, FAULT)
  - lane-index constants (A_LANE=0, B_LANE=1, C_LANE=2)
  - shared default parameter values
- One sub-module, fourwires_sync: N-stage async-reset bit synchronizer, instantiated four times.

Test Plan:
1. Reset, then hold w=x=y=z=0 for 20 cycles -> a=b=c=0, valid never asserted, mismatch=0, err_cnt=0.
2. At a stable cycle, set w=1,x=1,y=1,z=0 -> exactly 6 edges later a=1,b=1,c=0 and valid high for 1 cycle; no further pulse.
3. Pulse z=1 for 2 cycles, then back to 0 -> c stays 0 and valid never asserts. Then hold z=1 for 4+ cycles -> c=1 with one valid pulse at edge 6.
4. Drive x=1,y=0 for 10 cycles -> mismatch=1, err_cnt=1, err_sticky=1, a/b/c unchanged. Restore y=1 -> mismatch=0; outputs resettle to {c,b,a} with one valid pulse only if the value changed.
5. Toggle y 300 times against fixed x -> err_cnt saturates at 255. Assert err_clr on the same cycle as a new event -> err_cnt=1, err_sticky=1. Assert err_clr alone -> err_cnt=0, err_sticky=0.
6. Assert rst_n=0 mid-settling (2 cycles into a w change) -> all outputs 0 immediately. After release with w=1, a=1 arrives exactly 6 edges after release, with one valid pulse.

Source files
------------

// File: rtl/fourwires_pkg.sv
// Shared types and constants for the fourwires receive path.
package fourwires_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 4;
  localparam int unsigned ERR_CNT_W_DEF     = 8;

  localparam int unsigned A_LANE    = 0;
  localparam int unsigned B_LANE    = 1;
  localparam int unsigned C_LANE    = 2;
  localparam int unsigned NUM_LANES = 3;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    SETTLING = 2'd1,
    FAULT    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/fourwires_sync.sv
// N-stage bit synchronizer with asynchronous active-low reset.
module fourwires_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fourwires_rx.sv
// Far end of the fourwires fan-out: synchronizes w/x/y/z, checks the duplicated
// b lanes, debounces the sampled word and reconstructs registered a/b/c.
module fourwires_rx
  import fourwires_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned ERR_CNT_W     = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w,
  input  logic                 x,
  input  logic                 y,
  input  logic                 z,
  input  logic                 err_clr,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 valid,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic ws, xs, ys, zs;

  fourwires_sync #(.STAGES(SYNC_STAGES)) u_sync_w (.clk(clk), .rst_n(rst_n), .d(w), .q(ws));
  fourwires_sync #(.STAGES(SYNC_STAGES)) u_sync_x (.clk(clk), .rst_n(rst_n), .d(x), .q(xs));
  fourwires_sync #(.STAGES(SYNC_STAGES)) u_sync_y (.clk(clk), .rst_n(rst_n), .d(y), .q(ys));
  fourwires_sync #(.STAGES(SYNC_STAGES)) u_sync_z (.clk(clk), .rst_n(rst_n), .d(z), .q(zs));

  rx_state_e              state;
  logic [NUM_LANES-1:0]   out_q;
  logic [NUM_LANES-1:0]   cand;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_LANES-1:0]   s_word;
  logic                   lane_mm;
  logic                   mm_event;

  assign s_word   = {zs, xs, ws};
  assign lane_mm  = xs ^ ys;
  // Event is the 0->1 transition of the registered flag, counted on the same edge.
  assign mm_event = lane_mm & ~mismatch;

  assign a = out_q[A_LANE];
  assign b = out_q[B_LANE];
  assign c = out_q[C_LANE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      out_q      <= '0;
      cand       <= '0;
      cnt        <= '0;
      valid      <= 1'b0;
      mismatch   <= 1'b0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      valid    <= 1'b0;
      mismatch <= lane_mm;

      if (lane_mm) begin
        state <= FAULT;
        cnt   <= '0;
      end else begin
        case (state)
          FAULT: begin
            cand  <= s_word;
            cnt   <= '0;
            state <= SETTLING;
          end
          LOCKED: begin
            if (s_word != out_q) begin
              cand  <= s_word;
              cnt   <= '0;
              state <= SETTLING;
            end
          end
          SETTLING: begin
            if (s_word != cand) begin
              cand <= s_word;
              cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              // A glitch that settles back to the held value is silent.
              if (cand != out_q) begin
                out_q <= cand;
                valid <= 1'b1;
              end
              state <= LOCKED;
            end
          end
          default: state <= LOCKED;
        endcase
      end

      // A new event takes precedence over a simultaneous clear.
      if (mm_event) begin
        err_sticky <= 1'b1;
        if (err_clr) begin
          err_cnt <= ERR_CNT_W'(1);
        end else if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end else if (err_clr) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fourwires_rx.sv
// Scoreboard bench for fourwires_rx: expected {c,b,a} updates are queued with their
// arrival cycle; a monitor pops them whenever valid is seen.
module tb_fourwires_rx;
  import fourwires_pkg::*;

  // Drive at negedge of cycle N -> sampled at edge N+1 -> update at edge N+7.
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0, err_clr = 1'b0;
  logic       a, b, c, valid, mismatch, err_sticky;
  logic [7:0] err_cnt;

  typedef struct {
    logic [2:0] abc;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  fourwires_rx dut (
    .clk(clk), .rst_n(rst_n), .w(w), .x(x), .y(y), .z(z), .err_clr(err_clr),
    .a(a), .b(b), .c(c), .valid(valid), .mismatch(mismatch),
    .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_update(input logic [2:0] v);
    exp_t e;
    e.abc = v;
    e.at  = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {29'd0, c, b, a}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("valid_value", {29'd0, c, b, a}, {29'd0, e.abc});
        check("valid_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    // 1: reset and idle
    step(3);
    rst_n = 1'b1;
    step(20);
    check("idle_abc", {c, b, a}, 3'b000);
    check("idle_mismatch", mismatch, 0);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_sticky", err_sticky, 0);

    // 2: clean change
    w = 1'b1; x = 1'b1; y = 1'b1;
    expect_update(3'b011);
    step(12);
    drain();
    check("t2_abc", {c, b, a}, 3'b011);

    // 3: short glitch on z is filtered, then a held change passes
    z = 1'b1;
    step(2);
    z = 1'b0;
    step(15);
    check("t3_glitch_c", c, 0);
    z = 1'b1;
    expect_update(3'b111);
    step(12);
    drain();
    check("t3_abc", {c, b, a}, 3'b111);

    // 4: lane fault, with w changing underneath
    y = 1'b0; w = 1'b0;
    step(10);
    check("t4_mismatch", mismatch, 1);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_sticky", err_sticky, 1);
    check("t4_hold_abc", {c, b, a}, 3'b111);
    y = 1'b1;
    expect_update(3'b110);
    step(4);
    check("t4_mismatch_clr", mismatch, 0);
    step(8);
    drain();
    check("t4_abc", {c, b, a}, 3'b110);
    check("t4_err_cnt_after", err_cnt, 1);

    // 5: saturation, clear/event collision, plain clear
    repeat (300) begin
      y = 1'b0;
      step(1);
      y = 1'b1;
      step(1);
    end
    step(10);
    check("t5_sat", err_cnt, 255);
    check("t5_sticky", err_sticky, 1);
    check("t5_abc", {c, b, a}, 3'b110);
    y = 1'b0;
    step(2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t5_clr_event_cnt", err_cnt, 1);
    check("t5_clr_event_sticky", err_sticky, 1);
    y = 1'b1;
    step(10);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t5_clr_cnt", err_cnt, 0);
    check("t5_clr_sticky", err_sticky, 0);
    check("t5_abc_final", {c, b, a}, 3'b110);

    // 6: reset in the middle of settling
    w = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_abc", {c, b, a}, 3'b000);
    check("t6_rst_valid", valid, 0);
    check("t6_rst_mismatch", mismatch, 0);
    step(2);
    rst_n = 1'b1;
    expect_update(3'b111);
    step(12);
    drain();
    check("t6_abc", {c, b, a}, 3'b111);
    check("t6_err_cnt", err_cnt, 0);

    step(5);
    check("final_queue_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
